// File: rtl/bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// bus_master_arbiter
//
// Shares one bus slave port between two CPU bus masters:
//   M0 = data-memory port, M1 = instruction-fetch port.
// A registered grant FSM (IDLE / G0 / G1) selects which master is routed
// combinationally to the slave. While both masters keep requesting, a
// bounded-burst counter lets M0 complete at most MAX_BURST transactions
// before M1 is served, so M0 cannot starve M1.
//
// Optional build macro:
//   BUS_ARB_ROUND_ROBIN_EN - strict alternation between requesting masters.
//                            The burst counter is removed. An IDLE tie goes
//                            to the master not served last.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   mN_address/read/write/
//   mN_data_wr/mask             master N request (N = 0, 1)
//   mN_stall                    stall back to master N
//   mN_data_rd, mN_data_rd_2    slave read data, broadcast to both masters
//   s_address/read/write/
//   s_data_wr/mask              request routed to the slave
//   s_stall                     slave busy
//   s_data_rd, s_data_rd_2      slave read data
//   grant                       one-hot grant {G1, G0}, 00 = idle
// -----------------------------------------------------------------------------
module bus_master_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_data_wr,
  input  logic [3:0]  m0_mask,
  output logic        m0_stall,
  output logic [31:0] m0_data_rd,
  output logic [31:0] m0_data_rd_2,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_data_wr,
  input  logic [3:0]  m1_mask,
  output logic        m1_stall,
  output logic [31:0] m1_data_rd,
  output logic [31:0] m1_data_rd_2,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_data_wr,
  output logic [3:0]  s_mask,
  input  logic        s_stall,
  input  logic [31:0] s_data_rd,
  input  logic [31:0] s_data_rd_2,
  output logic [1:0]  grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       req0, req1;
  logic       gnt0, gnt1;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // 1 = M1 was the last master to complete a transaction.
  logic last_m1_q, last_m1_d;
`else
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       burst_limit;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // The M0 completion happening now would be the MAX_BURST-th in a row.
  assign burst_limit = ({1'b0, burst_cnt_q} + 5'd1) >= 5'(MAX_BURST);
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign gnt0 = (state_q == ST_G0);
  assign gnt1 = (state_q == ST_G1);

  assign grant = {gnt1, gnt0};

  // Slave-side routing: pass the granted master through, drive zeros when idle.
  always_comb begin
    s_address = '0;
    s_read    = 1'b0;
    s_write   = 1'b0;
    s_data_wr = '0;
    s_mask    = '0;
    if (gnt0) begin
      s_address = m0_address;
      s_read    = m0_read;
      s_write   = m0_write;
      s_data_wr = m0_data_wr;
      s_mask    = m0_mask;
    end else if (gnt1) begin
      s_address = m1_address;
      s_read    = m1_read;
      s_write   = m1_write;
      s_data_wr = m1_data_wr;
      s_mask    = m1_mask;
    end
  end

  // A waiting master is held off by its own request; the granted one sees the slave.
  assign m0_stall     = gnt0 ? s_stall : req0;
  assign m1_stall     = gnt1 ? s_stall : req1;
  assign m0_data_rd   = s_data_rd;
  assign m0_data_rd_2 = s_data_rd_2;
  assign m1_data_rd   = s_data_rd;
  assign m1_data_rd_2 = s_data_rd_2;

  always_comb begin
    state_d = state_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_m1_d = last_m1_q;
`else
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        if (req0 && req1) state_d = last_m1_q ? ST_G0 : ST_G1;
        else if (req0)    state_d = ST_G0;
        else if (req1)    state_d = ST_G1;
`else
        if (req0)      state_d = ST_G0;
        else if (req1) state_d = ST_G1;
`endif
      end
      ST_G0: begin
        // Grant is frozen while the slave stalls; a withdrawn request releases it.
        if (!req0) begin
          state_d = ST_IDLE;
        end else if (!s_stall) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_m1_d = 1'b0;
          if (req1) state_d = ST_G1;
`else
          if (req1 && burst_limit) begin
            state_d     = ST_G1;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = req1 ? sat_inc(burst_cnt_q) : 4'd0;
          end
`endif
        end
      end
      ST_G1: begin
        if (!req1) begin
          state_d = ST_IDLE;
        end else if (!s_stall) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_m1_d = 1'b1;
`else
          burst_cnt_d = '0;
`endif
          if (req0) state_d = ST_G0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_m1_q <= 1'b1;
`else
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_m1_q <= last_m1_d;
`else
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
module tb_bus_master_arbiter;

  localparam int MB = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_data_wr, m1_data_wr;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_stall, m1_stall;
  logic [31:0] m0_data_rd, m0_data_rd_2, m1_data_rd, m1_data_rd_2;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_data_wr;
  logic [3:0]  s_mask;
  logic        s_stall;
  logic [31:0] s_data_rd, s_data_rd_2;
  logic [1:0]  grant;

  int checks;
  int failures;

  bus_master_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_data_wr(m0_data_wr), .m0_mask(m0_mask), .m0_stall(m0_stall),
    .m0_data_rd(m0_data_rd), .m0_data_rd_2(m0_data_rd_2),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_data_wr(m1_data_wr), .m1_mask(m1_mask), .m1_stall(m1_stall),
    .m1_data_rd(m1_data_rd), .m1_data_rd_2(m1_data_rd_2),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_data_wr(s_data_wr), .s_mask(s_mask), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 none, 0 = M0, 1 = M1), how many
  // M0 completions have happened back-to-back while M1 waited, and who was
  // served last (round-robin build).
  int mo;
  int mrun;
  int mlast;

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_data_wr = '0; m0_mask = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_data_wr = '0; m1_mask = '0;
    s_stall = 0; s_data_rd = '0; s_data_rd_2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    mo = -1; mrun = 0; mlast = 1;
  endtask

  task automatic model_check_and_step();
    logic        r[2];
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    logic        er, ew, es0, es1;
    logic [3:0]  em;
    r[0] = m0_read | m0_write;
    r[1] = m1_read | m1_write;
    eg = (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00;
    ea = '0; er = 0; ew = 0; ed = '0; em = '0;
    if (mo == 0) begin ea = m0_address; er = m0_read; ew = m0_write; ed = m0_data_wr; em = m0_mask; end
    if (mo == 1) begin ea = m1_address; er = m1_read; ew = m1_write; ed = m1_data_wr; em = m1_mask; end
    es0 = (mo == 0) ? s_stall : r[0];
    es1 = (mo == 1) ? s_stall : r[1];
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_s_address", s_address, ea);
    chk("rnd_s_read", 32'(s_read), 32'(er));
    chk("rnd_s_write", 32'(s_write), 32'(ew));
    chk("rnd_s_data_wr", s_data_wr, ed);
    chk("rnd_s_mask", 32'(s_mask), 32'(em));
    chk("rnd_m0_stall", 32'(m0_stall), 32'(es0));
    chk("rnd_m1_stall", 32'(m1_stall), 32'(es1));
    chk("rnd_m0_data_rd", m0_data_rd, s_data_rd);
    chk("rnd_m1_data_rd", m1_data_rd, s_data_rd);
    chk("rnd_m0_data_rd_2", m0_data_rd_2, s_data_rd_2);
    chk("rnd_m1_data_rd_2", m1_data_rd_2, s_data_rd_2);
    // advance to the state after the coming clock edge
    if (!rst_n) begin
      mo = -1; mrun = 0; mlast = 1;
    end else if (mo < 0) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (r[0] && r[1]) mo = (mlast == 1) ? 0 : 1;
      else if (r[0])    mo = 0;
      else if (r[1])    mo = 1;
`else
      if (r[0])      mo = 0;
      else if (r[1]) mo = 1;
`endif
    end else if (!r[mo]) begin
      mo = -1;
    end else if (!s_stall) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      mlast = mo;
      if (r[1-mo]) mo = 1 - mo;
`else
      if (mo == 0) begin
        if (r[1] && mrun + 1 >= MB) begin
          mo = 1; mrun = 0;
        end else begin
          mrun = r[1] ? ((mrun < 15) ? mrun + 1 : 15) : 0;
        end
      end else begin
        mrun = 0;
        if (r[0]) mo = 0;
      end
`endif
    end
  endtask

  typedef struct {
    logic       m0r;
    logic       m1r;
    logic       stall;
    logic [1:0] g;
    logic       sr;
    int         sel;
    logic       st0;
    logic       st1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] exp_addr;
    logic [1:0]  exp_g;
    int          m0_run, max_run;
    logic [31:0] wa, ma, md;

    checks = 0; failures = 0;
    rst_n = 0;
    clear_inputs();
    mo = -1; mrun = 0; mlast = 1;

    // Single M1 read with two stall cycles, then a tie held in G0 by a stall.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0};

    do_reset();
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_s_read", 32'(s_read), 32'd0);
    chk("reset_s_address", s_address, 32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      m0_address = 32'h1000_0000; m1_address = 32'h2000_0000;
      m0_read = tbl[i].m0r; m1_read = tbl[i].m1r; s_stall = tbl[i].stall;
      s_data_rd = 32'hA5A5_0000 + 32'(i); s_data_rd_2 = 32'h5A5A_0000 + 32'(i);
      #1;
      exp_addr = (tbl[i].sel == 1) ? 32'h1000_0000 : (tbl[i].sel == 2) ? 32'h2000_0000 : 32'h0;
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_s_read", i), 32'(s_read), 32'(tbl[i].sr));
      chk($sformatf("tbl%0d_s_write", i), 32'(s_write), 32'd0);
      chk($sformatf("tbl%0d_s_address", i), s_address, exp_addr);
      chk($sformatf("tbl%0d_m0_stall", i), 32'(m0_stall), 32'(tbl[i].st0));
      chk($sformatf("tbl%0d_m1_stall", i), 32'(m1_stall), 32'(tbl[i].st1));
      chk($sformatf("tbl%0d_m1_data_rd", i), m1_data_rd, 32'hA5A5_0000 + 32'(i));
      chk($sformatf("tbl%0d_m0_data_rd_2", i), m0_data_rd_2, 32'h5A5A_0000 + 32'(i));
    end

    // Both masters request continuously: burst fairness / alternation.
    do_reset();
    m0_run = 0; max_run = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      m0_read = 1; m1_read = 1; s_stall = 0;
      #1;
      if (i == 0) exp_g = 2'b00;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      else exp_g = (((i - 1) % 2) == 0) ? 2'b01 : 2'b10;
`else
      else exp_g = (((i - 1) % (MB + 1)) < MB) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("burst%0d_grant", i), 32'(grant), 32'(exp_g));
      if (grant == 2'b01) m0_run++;
      else m0_run = 0;
      if (m0_run > max_run) max_run = m0_run;
    end
    chk("burst_m1_max_wait_le_MB", 32'(max_run <= MB), 32'd1);

    // M0 masked write while M1 waits; M1 must never leak onto the slave.
    do_reset();
    wa = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m0_address = wa; m0_write = 1; m0_mask = 4'b0011; m0_data_wr = 32'hDEADBEEF;
      m1_address = ~wa; m1_read = 1; m1_mask = 4'b1100; m1_data_wr = 32'h0BAD_F00D;
      s_stall = (i >= 1 && i <= 3);
      #1;
      if (i == 0) begin
        chk("wr_idle_grant", 32'(grant), 32'd0);
        chk("wr_idle_s_write", 32'(s_write), 32'd0);
      end else begin
        chk($sformatf("wr%0d_grant", i), 32'(grant), 32'b01);
        chk($sformatf("wr%0d_s_write", i), 32'(s_write), 32'd1);
        chk($sformatf("wr%0d_s_read", i), 32'(s_read), 32'd0);
        chk($sformatf("wr%0d_s_mask", i), 32'(s_mask), 32'b0011);
        chk($sformatf("wr%0d_s_data_wr", i), s_data_wr, 32'hDEADBEEF);
        chk($sformatf("wr%0d_s_address", i), s_address, wa);
        chk($sformatf("wr%0d_m1_stall", i), 32'(m1_stall), 32'd1);
        chk($sformatf("wr%0d_m0_stall", i), 32'(m0_stall), 32'(i <= 3));
      end
    end

    // Reset asserted while G1 is stalled mid-access.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m1_read = 1; m1_address = 32'hCAFE_0040; s_stall = 1;
      rst_n = (i != 2);
      #1;
      case (i)
        0: chk("rst0_grant", 32'(grant), 32'd0);
        1: begin
          chk("rst1_grant", 32'(grant), 32'b10);
          chk("rst1_s_read", 32'(s_read), 32'd1);
          chk("rst1_s_address", s_address, 32'hCAFE_0040);
        end
        2: chk("rst2_grant", 32'(grant), 32'b10);
        3: begin
          chk("rst3_grant", 32'(grant), 32'd0);
          chk("rst3_s_read", 32'(s_read), 32'd0);
          chk("rst3_s_write", 32'(s_write), 32'd0);
          chk("rst3_m1_stall", 32'(m1_stall), 32'd1);
        end
        default: begin
          chk("rst4_grant", 32'(grant), 32'b10);
          chk("rst4_s_read", 32'(s_read), 32'd1);
        end
      endcase
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int op0, op1;
      @(negedge clk);
      op0 = $urandom_range(0, 4);
      op1 = $urandom_range(0, 4);
      m0_read = (op0 == 1) || (op0 == 3); m0_write = (op0 == 2) || (op0 == 4);
      m1_read = (op1 == 1) || (op1 == 3); m1_write = (op1 == 2) || (op1 == 4);
      m0_address = $urandom; m1_address = $urandom;
      m0_data_wr = $urandom; m1_data_wr = $urandom;
      m0_mask = 4'($urandom); m1_mask = 4'($urandom);
      s_stall = ($urandom_range(0, 2) == 0);
      s_data_rd = $urandom; s_data_rd_2 = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      model_check_and_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
